decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: registered decode of one instruction per
// accepted handshake, with flush and hold-under-backpressure.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_code,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [31:0] out_imm,
  output logic        out_op1_sel,
  output logic        out_op2_sel,
  output logic        out_we,
  output logic [31:0] out_pc,
  output logic        out_illegal
);

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_SLL  = 6'd2;
  localparam logic [5:0] ALU_SLT  = 6'd3;
  localparam logic [5:0] ALU_SLTU = 6'd4;
  localparam logic [5:0] ALU_XOR  = 6'd5;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_SRA  = 6'd7;
  localparam logic [5:0] ALU_OR   = 6'd8;
  localparam logic [5:0] ALU_AND  = 6'd9;
  localparam logic [5:0] ALU_LB   = 6'd10;
  localparam logic [5:0] ALU_LH   = 6'd11;
  localparam logic [5:0] ALU_LW   = 6'd12;
  localparam logic [5:0] ALU_LBU  = 6'd13;
  localparam logic [5:0] ALU_LHU  = 6'd14;
  localparam logic [5:0] ALU_SB   = 6'd15;
  localparam logic [5:0] ALU_SH   = 6'd16;
  localparam logic [5:0] ALU_SW   = 6'd17;
  localparam logic [5:0] ALU_BEQ  = 6'd18;
  localparam logic [5:0] ALU_BNE  = 6'd19;
  localparam logic [5:0] ALU_BLT  = 6'd20;
  localparam logic [5:0] ALU_BGE  = 6'd21;
  localparam logic [5:0] ALU_BLTU = 6'd22;
  localparam logic [5:0] ALU_BGEU = 6'd23;
  localparam logic [5:0] ALU_JAL  = 6'd24;
  localparam logic [5:0] ALU_JALR = 6'd25;
  localparam logic [5:0] ALU_LUI  = 6'd26;

  typedef struct packed {
    logic [5:0]  code;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        op1_sel;
    logic        op2_sel;
    logic        we;
    logic [31:0] pc;
    logic        illegal;
  } id_ex_t;

  id_ex_t d;
  id_ex_t q;
  logic   vq;
  logic   accept;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                  in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'h000};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                  in_inst[20], in_inst[30:21], 1'b0};

  assign in_ready = !flush && (!vq || out_ready);
  assign accept   = in_valid && in_ready;

  // opcode/funct decode into the next bundle
  always_comb begin
    logic [5:0]  code;
    logic [31:0] imm;
    logic        s1, s2, wr, ill;
    code = ALU_ADD;
    imm  = 32'h0;
    s1   = 1'b0;
    s2   = 1'b0;
    wr   = 1'b0;
    ill  = 1'b0;
    unique case (1'b1)
      (opc == 7'h37): begin
        code = ALU_LUI; imm = imm_u; s2 = 1'b1; wr = 1'b1;
      end
      (opc == 7'h17): begin
        imm = imm_u; s1 = 1'b1; s2 = 1'b1; wr = 1'b1;
      end
      (opc == 7'h6f): begin
        code = ALU_JAL; imm = imm_j;
        s1 = 1'b1; s2 = 1'b1; wr = 1'b1;
      end
      (opc == 7'h67): begin
        code = ALU_JALR; imm = imm_i; s2 = 1'b1; wr = 1'b1;
        ill = (f3 != 3'd0);
      end
      (opc == 7'h63): begin
        imm = imm_b;
        unique case (f3)
          3'd0:    code = ALU_BEQ;
          3'd1:    code = ALU_BNE;
          3'd4:    code = ALU_BLT;
          3'd5:    code = ALU_BGE;
          3'd6:    code = ALU_BLTU;
          3'd7:    code = ALU_BGEU;
          default: ill = 1'b1;
        endcase
      end
      (opc == 7'h03): begin
        imm = imm_i; s2 = 1'b1; wr = 1'b1;
        unique case (f3)
          3'd0:    code = ALU_LB;
          3'd1:    code = ALU_LH;
          3'd2:    code = ALU_LW;
          3'd4:    code = ALU_LBU;
          3'd5:    code = ALU_LHU;
          default: ill = 1'b1;
        endcase
      end
      (opc == 7'h23): begin
        imm = imm_s; s2 = 1'b1;
        unique case (f3)
          3'd0:    code = ALU_SB;
          3'd1:    code = ALU_SH;
          3'd2:    code = ALU_SW;
          default: ill = 1'b1;
        endcase
      end
      (opc == 7'h13): begin
        imm = imm_i; s2 = 1'b1; wr = 1'b1;
        unique case (f3)
          3'd0: code = ALU_ADD;
          3'd1: begin
            code = ALU_SLL;
            ill  = (f7 != 7'h00);
          end
          3'd2: code = ALU_SLT;
          3'd3: code = ALU_SLTU;
          3'd4: code = ALU_XOR;
          3'd5: begin
            code = f7[5] ? ALU_SRA : ALU_SRL;
            ill  = (f7 != 7'h00) && (f7 != 7'h20);
          end
          3'd6: code = ALU_OR;
          3'd7: code = ALU_AND;
        endcase
      end
      (opc == 7'h33): begin
        wr = 1'b1;
        unique case (f3)
          3'd0: code = f7[5] ? ALU_SUB : ALU_ADD;
          3'd1: code = ALU_SLL;
          3'd2: code = ALU_SLT;
          3'd3: code = ALU_SLTU;
          3'd4: code = ALU_XOR;
          3'd5: code = f7[5] ? ALU_SRA : ALU_SRL;
          3'd6: code = ALU_OR;
          3'd7: code = ALU_AND;
        endcase
        ill = !((f7 == 7'h00) ||
                ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      (opc == 7'h0f),
      (opc == 7'h73): imm = imm_i;
      default: ill = 1'b1;
    endcase
    if (ill) begin
      code = ALU_ADD;
      s1   = 1'b0;
      s2   = 1'b0;
      wr   = 1'b0;
    end
    d         = '0;
    d.code    = code;
    d.rs1     = in_inst[19:15];
    d.rs2     = in_inst[24:20];
    d.rd      = in_inst[11:7];
    d.imm     = imm;
    d.op1_sel = s1;
    d.op2_sel = s2;
    d.we      = wr && (in_inst[11:7] != 5'd0);
    d.pc      = in_pc;
    d.illegal = ill;
  end

  // decode/execute pipeline register with flush and hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vq     <= 1'b0;
      q      <= '0;
      q.code <= ALU_ADD;
    end else if (flush) begin
      vq <= 1'b0;
    end else if (accept) begin
      vq <= 1'b1;
      q  <= d;
    end else if (out_ready) begin
      vq <= 1'b0;
    end
  end

  assign out_valid   = vq;
  assign out_code    = q.code;
  assign out_rs1     = q.rs1;
  assign out_rs2     = q.rs2;
  assign out_rd      = q.rd;
  assign out_imm     = q.imm;
  assign out_op1_sel = q.op1_sel;
  assign out_op2_sel = q.op2_sel;
  assign out_we      = q.we;
  assign out_pc      = q.pc;
  assign out_illegal = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected bundles come from
// an independent RV32I decode model and are popped on output.
module tb_decode_stage;

  localparam logic [5:0] A_ADD  = 6'd0;
  localparam logic [5:0] A_SUB  = 6'd1;
  localparam logic [5:0] A_SLL  = 6'd2;
  localparam logic [5:0] A_SLT  = 6'd3;
  localparam logic [5:0] A_SLTU = 6'd4;
  localparam logic [5:0] A_XOR  = 6'd5;
  localparam logic [5:0] A_SRL  = 6'd6;
  localparam logic [5:0] A_SRA  = 6'd7;
  localparam logic [5:0] A_OR   = 6'd8;
  localparam logic [5:0] A_AND  = 6'd9;
  localparam logic [5:0] A_LB   = 6'd10;
  localparam logic [5:0] A_LH   = 6'd11;
  localparam logic [5:0] A_LW   = 6'd12;
  localparam logic [5:0] A_LBU  = 6'd13;
  localparam logic [5:0] A_LHU  = 6'd14;
  localparam logic [5:0] A_SB   = 6'd15;
  localparam logic [5:0] A_SH   = 6'd16;
  localparam logic [5:0] A_SW   = 6'd17;
  localparam logic [5:0] A_BEQ  = 6'd18;
  localparam logic [5:0] A_BNE  = 6'd19;
  localparam logic [5:0] A_BLT  = 6'd20;
  localparam logic [5:0] A_BGE  = 6'd21;
  localparam logic [5:0] A_BLTU = 6'd22;
  localparam logic [5:0] A_BGEU = 6'd23;
  localparam logic [5:0] A_JAL  = 6'd24;
  localparam logic [5:0] A_JALR = 6'd25;
  localparam logic [5:0] A_LUI  = 6'd26;

  localparam logic [88:0] RST_VEC = {A_ADD, 83'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_code;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic        out_op1_sel, out_op2_sel, out_we;
  logic [31:0] out_pc;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;
  logic [88:0] sb[$];

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_op1_sel(out_op1_sel),
    .out_op2_sel(out_op2_sel), .out_we(out_we),
    .out_pc(out_pc), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [88:0] dut_vec();
    return {out_code, out_rs1, out_rs2, out_rd, out_imm,
            out_op1_sel, out_op2_sel, out_we, out_pc, out_illegal};
  endfunction

  function automatic logic [88:0] model(input logic [31:0] i,
                                        input logic [31:0] pc);
    logic [5:0]  c;
    logic [31:0] im;
    logic        a, b, w, il;
    logic [2:0]  f3;
    logic [6:0]  f7;
    f3 = i[14:12];
    f7 = i[31:25];
    c = A_ADD; im = 32'h0; a = 0; b = 0; w = 0; il = 0;
    case (i[6:0])
      7'h37: begin c = A_LUI; im = {i[31:12], 12'h0}; b = 1; w = 1; end
      7'h17: begin im = {i[31:12], 12'h0}; a = 1; b = 1; w = 1; end
      7'h6f: begin
        c = A_JAL; a = 1; b = 1; w = 1;
        im = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      7'h67: begin
        c = A_JALR; b = 1; w = 1;
        im = {{20{i[31]}}, i[31:20]};
        il = (f3 != 0);
      end
      7'h63: begin
        im = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        case (f3)
          0: c = A_BEQ;  1: c = A_BNE;
          4: c = A_BLT;  5: c = A_BGE;
          6: c = A_BLTU; 7: c = A_BGEU;
          default: il = 1;
        endcase
      end
      7'h03: begin
        im = {{20{i[31]}}, i[31:20]}; b = 1; w = 1;
        case (f3)
          0: c = A_LB;  1: c = A_LH; 2: c = A_LW;
          4: c = A_LBU; 5: c = A_LHU;
          default: il = 1;
        endcase
      end
      7'h23: begin
        im = {{20{i[31]}}, i[31:25], i[11:7]}; b = 1;
        case (f3)
          0: c = A_SB; 1: c = A_SH; 2: c = A_SW;
          default: il = 1;
        endcase
      end
      7'h13: begin
        im = {{20{i[31]}}, i[31:20]}; b = 1; w = 1;
        case (f3)
          0: c = A_ADD;  2: c = A_SLT;
          3: c = A_SLTU; 4: c = A_XOR;
          6: c = A_OR;   7: c = A_AND;
          1: if (f7 == 0) c = A_SLL; else il = 1;
          default: begin
            if (f7 == 7'h00) c = A_SRL;
            else if (f7 == 7'h20) c = A_SRA;
            else il = 1;
          end
        endcase
      end
      7'h33: begin
        w = 1;
        if (f7 == 7'h00) begin
          case (f3)
            0: c = A_ADD;  1: c = A_SLL;
            2: c = A_SLT;  3: c = A_SLTU;
            4: c = A_XOR;  5: c = A_SRL;
            6: c = A_OR;   default: c = A_AND;
          endcase
        end else if (f7 == 7'h20 && f3 == 0) c = A_SUB;
        else if (f7 == 7'h20 && f3 == 5) c = A_SRA;
        else il = 1;
      end
      7'h0f, 7'h73: im = {{20{i[31]}}, i[31:20]};
      default: il = 1;
    endcase
    if (il) begin c = A_ADD; a = 0; b = 0; w = 0; end
    if (i[11:7] == 5'd0) w = 0;
    return {c, i[19:15], i[24:20], i[11:7], im, a, b, w, pc, il};
  endfunction

  // drive one instruction for one cycle; queue it if accepted
  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    #1;
    if (in_ready) sb.push_back(model(inst, pc));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 4 && !out_valid; n++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_inst = 0; in_pc = 0;
    flush = 0; out_ready = 1;
    #3;
    checks++;
    if (out_valid !== 1'b0 || dut_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL reset valid=%b got=%h want=%h",
               out_valid, dut_vec(), RST_VEC);
    end
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    logic [88:0] e;
    out_ready = 1;
    send(32'h00500093, 32'h0000_1000);
    wait_valid();
    checks++;
    if (!out_valid || sb.size() == 0) begin
      errors++;
      $display("FAIL addi_timeout valid=%b q=%0d", out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if (dut_vec() !== e) begin
        errors++;
        $display("FAIL addi got=%h want=%h", dut_vec(), e);
      end
    end
    checks++;
    if (out_code !== A_ADD || out_rd !== 5'd1 || out_rs1 !== 5'd0 ||
        out_imm !== 32'h5 || out_op2_sel !== 1'b1 || out_we !== 1'b1) begin
      errors++;
      $display("FAIL addi_fields code=%0d rd=%0d imm=%h we=%b want 0/1/5/1",
               out_code, out_rd, out_imm, out_we);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_beq_lui();
    logic [88:0] e;
    out_ready = 1;
    send(32'hFE208EE3, 32'h0000_2000);
    wait_valid();
    checks++;
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    if (!out_valid || dut_vec() !== e || out_code !== A_BEQ ||
        out_imm !== 32'hFFFFFFFC || out_we !== 0 || out_op2_sel !== 0) begin
      errors++;
      $display("FAIL beq got=%h want=%h", dut_vec(), e);
    end
    @(posedge clk); #1;
    send(32'h123452B7, 32'h0000_2004);
    wait_valid();
    checks++;
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    if (!out_valid || dut_vec() !== e || out_code !== A_LUI ||
        out_rd !== 5'd5 || out_imm !== 32'h12345000 || out_we !== 1) begin
      errors++;
      $display("FAIL lui got=%h want=%h", dut_vec(), e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_formats();
    logic [31:0] v[18];
    logic [88:0] e;
    v[0]  = {7'h20, 5'd6, 5'd5, 3'd5, 5'd4, 7'h33};
    v[1]  = {7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
    v[2]  = {7'h01, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
    v[3]  = {7'h20, 5'd3, 5'd1, 3'd1, 5'd2, 7'h13};
    v[4]  = {7'h20, 5'd3, 5'd1, 3'd5, 5'd2, 7'h13};
    v[5]  = {12'hFF8, 5'd2, 3'd2, 5'd7, 7'h03};
    v[6]  = {7'h00, 5'd7, 5'd2, 3'd2, 5'h0C, 7'h23};
    v[7]  = {1'b1, 10'h155, 1'b1, 8'hA5, 5'd1, 7'h6F};
    v[8]  = {12'h010, 5'd1, 3'd1, 5'd1, 7'h67};
    v[9]  = {12'h804, 5'd1, 3'd0, 5'd0, 7'h67};
    v[10] = {20'hABCDE, 5'd9, 7'h17};
    v[11] = {7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33};
    v[12] = 32'h0FF0000F;
    v[13] = 32'h00000073;
    v[14] = {12'h004, 5'd1, 3'd3, 5'd8, 7'h03};
    v[15] = {7'h00, 5'd2, 5'd1, 3'd2, 5'd0, 7'h63};
    v[16] = {7'h02, 5'd2, 5'd1, 3'd1, 5'h08, 7'h63};
    v[17] = {12'hF0F, 5'd3, 3'd4, 5'd4, 7'h13};
    out_ready = 1;
    for (int k = 0; k < 18; k++) begin
      send(v[k], 32'h0000_3000 + 32'(k * 4));
      wait_valid();
      checks++;
      if (!out_valid || sb.size() == 0) begin
        errors++;
        $display("FAIL fmt%0d_timeout valid=%b", k, out_valid);
      end else begin
        e = sb.pop_front();
        if (dut_vec() !== e) begin
          errors++;
          $display("FAIL fmt%0d inst=%h got=%h want=%h",
                   k, v[k], dut_vec(), e);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [88:0] e;
    out_ready = 0;
    send(32'h00A00113, 32'h0000_4000);
    in_valid = 1; in_inst = 32'h40110233; in_pc = 32'h0000_4004;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready in_ready=%b valid=%b want 0/1",
               in_ready, out_valid);
    end
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #2;
      checks++;
      if (!out_valid || sb.size() != 1 || dut_vec() !== sb[0] ||
          in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d valid=%b rdy=%b got=%h",
                 n, out_valid, in_ready, dut_vec());
      end
    end
    out_ready = 1;
    #1;
    if (in_ready) sb.push_back(model(in_inst, in_pc));
    checks++;
    e = (sb.size() == 2) ? sb.pop_front() : '0;
    if (dut_vec() !== e || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first rdy=%b got=%h want=%h",
               in_ready, dut_vec(), e);
    end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0;
    @(posedge clk); #1;
    checks++;
    if (!out_valid || sb.size() != 1 || dut_vec() !== sb[0]) begin
      errors++;
      $display("FAIL bp_second valid=%b q=%0d got=%h",
               out_valid, sb.size(), dut_vec());
    end
    out_ready = 1;
    #1;
    if (sb.size() != 0) void'(sb.pop_front());
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain valid=%b q=%0d want 0/0",
               out_valid, sb.size());
    end
  endtask

  task automatic test_illegal_flush();
    logic [88:0] e;
    out_ready = 1;
    send(32'hFFFFFFFF, 32'h0000_5000);
    wait_valid();
    checks++;
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    if (!out_valid || dut_vec() !== e || out_illegal !== 1 ||
        out_we !== 0 || out_code !== A_ADD) begin
      errors++;
      $display("FAIL illegal got=%h want=%h", dut_vec(), e);
    end
    @(posedge clk); #1;
    out_ready = 0;
    send(32'h00500093, 32'h0000_5004);
    flush = 1; out_ready = 1;
    in_valid = 1; in_inst = 32'h123452B7; in_pc = 32'h0000_5008;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got=%b want 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    if (sb.size() != 0) void'(sb.pop_front());
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL flush_drop valid=%b q=%0d want 0/0",
               out_valid, sb.size());
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_noaccept valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [88:0] e;
    out_ready = 0;
    send(32'hFE208EE3, 32'h0000_6000);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dut_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL rst_async valid=%b got=%h want=%h",
               out_valid, dut_vec(), RST_VEC);
    end
    sb.delete();
    @(posedge clk); #2;
    rst_n = 1; out_ready = 1;
    in_valid = 1; in_inst = 32'h00500093; in_pc = 32'h0000_6004;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release valid=%b rdy=%b want 0/1",
               out_valid, in_ready);
    end
    sb.push_back(model(in_inst, in_pc));
    @(posedge clk); #1;
    in_valid = 0;
    checks++;
    e = sb.pop_front();
    if (!out_valid || dut_vec() !== e) begin
      errors++;
      $display("FAIL rst_first got=%h want=%h", dut_vec(), e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_beq_lui();
    test_formats();
    test_back_to_back();
    test_illegal_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
